// File: rtl/fc_pkg.sv
// Shared definitions for the fully connected classifier datapath:
// argmax FSM state encoding, default neuron data format, and a helper
// that produces the most-negative signed value for a given width.
package fc_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_RESULT} argmax_state_t;

  // Default neuron output format (Q10.5 signed)
  localparam int FC_WIDTH = 16;
  localparam int FC_FRAC  = 5;

  // Most-negative two's complement value of the given width, right-aligned
  function automatic logic [63:0] fc_min_signed(input int unsigned width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/fc_argmax_collector_if.sv
// Handshake bundle between the neuron array, the argmax collector and the
// result consumer. master = beat producer / result consumer side,
// slave = collector side.
interface fc_argmax_collector_if
  import fc_pkg::*;
#(
  parameter int WIDTH = FC_WIDTH,
  parameter int IDX_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_class;
  logic [WIDTH-1:0] out_score;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_class, out_score
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_class, out_score
  );
endinterface

// File: rtl/fc_score_buffer.sv
// Per-class score register file. One write port indexed by arrival order,
// one registered read port; reads outside DEPTH return zero.
module fc_score_buffer #(
  parameter int DEPTH = 10,
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [WIDTH-1:0]            rdata_q, rdata_d;

  // Next contents and read data; read sees pre-write contents
  always_comb begin
    mem_d   = mem_q;
    rdata_d = '0;
    if (we) mem_d[waddr] = wdata;
    if (raddr <= LAST) rdata_d = mem_q[raddr];
  end

  // Storage and read register, cleared on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q   <= '0;
      rdata_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/fc_argmax_collector.sv
// Argmax collector: accepts NUM_CLASSES signed neuron outputs per inference,
// tracks the running maximum (earliest index wins ties) and presents the
// winning class/score on a valid/ready result port.
// Optional: FC_ARGMAX_SCORE_BUF_EN adds a readable per-class score buffer
// (rd_addr/rd_data, 1-cycle read latency).
module fc_argmax_collector
  import fc_pkg::*;
#(
  parameter int NUM_CLASSES = 10,
  parameter int WIDTH       = FC_WIDTH,
  parameter int FRAC        = FC_FRAC,
  parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
`ifdef FC_ARGMAX_SCORE_BUF_EN
  input  logic [IDX_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data,
`endif
  fc_argmax_collector_if.slave io
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = WIDTH'(fc_min_signed(WIDTH));

  // FRAC only documents the score format; reject nonsensical configurations
  if (NUM_CLASSES < 2 || FRAC < 0 || FRAC >= WIDTH) begin : g_param_chk
    $error("fc_argmax_collector: invalid NUM_CLASSES/FRAC/WIDTH");
  end

  argmax_state_t    state_q, state_d;
  logic [IDX_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] max_val_q, max_val_d;
  logic [IDX_W-1:0] max_idx_q, max_idx_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_class_q, out_class_d;
  logic [WIDTH-1:0] out_score_q, out_score_d;

  logic             beat_win;
  logic [WIDTH-1:0] cand_val;
  logic [IDX_W-1:0] cand_idx;
  logic             beat_take;

  // A beat counts only in COLLECT and not on a restart cycle
  assign beat_take = (state_q == ST_COLLECT) && io.in_valid && !start;

  // Next-state: running compare, beat counting, result capture, handshakes
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    max_val_d   = max_val_q;
    max_idx_d   = max_idx_q;
    out_valid_d = out_valid_q;
    out_class_d = out_class_q;
    out_score_d = out_score_q;

    // First beat always loads; later beats need a strictly larger value
    beat_win = (count_q == '0) || ($signed(io.in_data) > $signed(max_val_q));
    cand_val = beat_win ? io.in_data : max_val_q;
    cand_idx = beat_win ? count_q    : max_idx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_COLLECT;
          count_d   = '0;
          max_idx_d = '0;
          max_val_d = MIN_VAL;
        end
      end
      ST_COLLECT: begin
        if (start) begin
          count_d   = '0;
          max_idx_d = '0;
          max_val_d = MIN_VAL;
        end else if (io.in_valid) begin
          max_val_d = cand_val;
          max_idx_d = cand_idx;
          if (count_q == LAST_IDX) begin
            state_d     = ST_RESULT;
            out_valid_d = 1'b1;
            out_class_d = cand_idx;
            out_score_d = cand_val;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      ST_RESULT: begin
        // start is ignored here, including alongside the accepting handshake
        if (io.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs, all cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      max_val_q   <= '0;
      max_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_score_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      max_val_q   <= max_val_d;
      max_idx_q   <= max_idx_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      out_score_q <= out_score_d;
    end
  end

  assign io.in_ready  = (state_q == ST_COLLECT);
  assign io.out_valid = out_valid_q;
  assign io.out_class = out_class_q;
  assign io.out_score = out_score_q;
  assign busy         = (state_q != ST_IDLE);

`ifdef FC_ARGMAX_SCORE_BUF_EN
  fc_score_buffer #(
    .DEPTH (NUM_CLASSES),
    .WIDTH (WIDTH),
    .AW    (IDX_W)
  ) u_score_buf (
    .clk   (clk),
    .reset (reset),
    .we    (beat_take),
    .waddr (count_q),
    .wdata (io.in_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );
`else
  logic unused_take;
  assign unused_take = beat_take;
`endif
endmodule

// File: tb/tb_fc_argmax_collector.sv
// Randomized self-checking bench for fc_argmax_collector. Expected results
// come from a plain argmax over the beat list that was sent; the score
// buffer (FC_ARGMAX_SCORE_BUF_EN) is modelled as the last value accepted
// at each arrival index.
module tb_fc_argmax_collector;
  localparam int NC = 10;
  localparam int W  = 16;
  localparam int IW = 4;

  typedef logic [W-1:0] beat_q_t[$];

  logic clk, reset, start, busy;
`ifdef FC_ARGMAX_SCORE_BUF_EN
  logic [IW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
`endif

  fc_argmax_collector_if #(.WIDTH(W), .IDX_W(IW)) io ();

  fc_argmax_collector #(.NUM_CLASSES(NC), .WIDTH(W), .FRAC(5), .IDX_W(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
`ifdef FC_ARGMAX_SCORE_BUF_EN
    .rd_addr (rd_addr),
    .rd_data (rd_data),
`endif
    .io    (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [W-1:0] buf_m [NC];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: first index holding the largest signed value
  task automatic ref_argmax(input beat_q_t v, output int cls, output logic [W-1:0] sc);
    cls = 0;
    sc  = v[0];
    for (int i = 1; i < v.size(); i++)
      if ($signed(v[i]) > $signed(sc)) begin
        sc  = v[i];
        cls = i;
      end
  endtask

  function automatic beat_q_t gen(input int mode);
    beat_q_t q;
    for (int i = 0; i < NC; i++)
      q.push_back(mode == 0 ? W'($urandom) : W'($urandom_range(0, 6)) - W'(3));
    return q;
  endfunction

  task automatic pulse_start(input bit with_beat);
    start       = 1'b1;
    io.in_valid = with_beat;
    io.in_data  = 16'd1000;
    @(posedge clk); #1;
    start       = 1'b0;
    io.in_valid = 1'b0;
  endtask

  // Send the first n beats of v, optionally with random valid gaps
  task automatic feed(input beat_q_t v, input int n, input bit gaps);
    int  k = 0;
    int  cyc = 0;
    bit  acc;
    while (k < n && cyc < 2000) begin
      io.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      io.in_data  = io.in_valid ? v[k] : W'($urandom);
      @(negedge clk);
      acc = io.in_valid && io.in_ready;
      @(posedge clk); #1;
      if (acc) begin
        buf_m[k] = v[k];
        k++;
      end
      cyc++;
    end
    io.in_valid = 1'b0;
    if (k < n) chk("feed_timeout", 64'(k), 64'(n));
  endtask

  // Called right after the edge accepting the last beat
  task automatic expect_result(input beat_q_t v, input int hold, input bit poke_start,
                               input bit start_at_ack);
    int           ec;
    logic [W-1:0] es;
    ref_argmax(v, ec, es);
    chk("valid_rise", 64'(io.out_valid), 1);
    chk("class", 64'(io.out_class), 64'(ec));
    chk("score", 64'(io.out_score), 64'(es));
    chk("busy_result", 64'(busy), 1);
    chk("rdy_result", 64'(io.in_ready), 0);
    io.out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      start       = poke_start && (i == 0);
      io.in_valid = 1'b1;
      io.in_data  = 16'h7fff;
      @(posedge clk); #1;
      start       = 1'b0;
      io.in_valid = 1'b0;
      chk("hold_valid", 64'(io.out_valid), 1);
      chk("hold_class", 64'(io.out_class), 64'(ec));
      chk("hold_score", 64'(io.out_score), 64'(es));
      chk("hold_rdy", 64'(io.in_ready), 0);
    end
    io.out_ready = 1'b1;
    start        = start_at_ack;
    @(posedge clk); #1;
    io.out_ready = 1'b0;
    start        = 1'b0;
    chk("valid_clr", 64'(io.out_valid), 0);
    chk("busy_clr", 64'(busy), 0);
    @(posedge clk); #1;
    chk("idle_stays", 64'(busy), 0);
  endtask

  task automatic run(input beat_q_t v, input bit gaps, input int hold, input bit ps,
                     input bit sa);
    pulse_start(1'b0);
    chk("rdy_collect", 64'(io.in_ready), 1);
    feed(v, NC, gaps);
    expect_result(v, hold, ps, sa);
  endtask

`ifdef FC_ARGMAX_SCORE_BUF_EN
  task automatic read_buf();
    for (int a = 0; a <= 12; a++) begin
      rd_addr = IW'(a);
      @(posedge clk); #1;
      chk("rd_data", 64'(rd_data), (a < NC) ? 64'(buf_m[a]) : 64'd0);
    end
  endtask
`endif

  beat_q_t v1, v2, vf;

  initial begin
    reset        = 1'b0;
    start        = 1'b0;
    io.in_valid  = 1'b0;
    io.in_data   = '0;
    io.out_ready = 1'b0;
`ifdef FC_ARGMAX_SCORE_BUF_EN
    rd_addr = '0;
`endif
    for (int i = 0; i < NC; i++) buf_m[i] = '0;
    #1;
    chk("rst_valid", 64'(io.out_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_rdy", 64'(io.in_ready), 0);
    chk("rst_class", 64'(io.out_class), 0);
    chk("rst_score", 64'(io.out_score), 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Basic argmax, tie at index 7 loses to index 3
    v1 = '{16'd3, 16'd7, 16'd2, 16'd9, 16'd1, 16'd0, 16'd4, 16'd9, 16'd5, 16'd6};
    run(v1, 1'b0, 0, 1'b0, 1'b0);
`ifdef FC_ARGMAX_SCORE_BUF_EN
    read_buf();
`endif

    // All negative, -2 at index 1 is the max
    v1 = '{16'hFFFB, 16'hFFFE, 16'hFFF8, 16'hFFFD, 16'hFFF7,
           16'hFFFC, 16'hFFF9, 16'hFFFA, 16'hFFF6, 16'hFFF5};
    run(v1, 1'b0, 0, 1'b0, 1'b0);

    // All most-negative: first beat loads unconditionally, index 0 wins
    v1 = '{NC{16'h8000}};
    run(v1, 1'b1, 2, 1'b0, 1'b0);

    // Gaps plus 5-cycle backpressure, start poked in RESULT and at the ack
    v1 = gen(0);
    run(v1, 1'b1, 5, 1'b1, 1'b1);

    // Restart mid-collection; the discarded beats are larger than the real max
    v1 = '{16'd500, 16'd600, 16'd700, 16'd800};
    pulse_start(1'b0);
    feed(v1, 4, 1'b0);
    pulse_start(1'b1);
    chk("restart_rdy", 64'(io.in_ready), 1);
    v2 = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd100, 16'd7, 16'd8, 16'd9};
    feed(v2, NC, 1'b1);
    expect_result(v2, 1, 1'b0, 1'b0);
`ifdef FC_ARGMAX_SCORE_BUF_EN
    read_buf();
`endif

    // Reset after 5 beats
    vf = gen(0);
    pulse_start(1'b0);
    feed(vf, 5, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(io.out_valid), 0);
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_rdy", 64'(io.in_ready), 0);
    for (int i = 0; i < NC; i++) buf_m[i] = '0;
    #3;
    reset = 1'b1;
    @(posedge clk); #1;
`ifdef FC_ARGMAX_SCORE_BUF_EN
    read_buf();
`endif
    run(vf, 1'b0, 0, 1'b0, 1'b0);

    // Randomized runs, alternating wide values and tie-heavy small ranges
    for (int it = 0; it < 12; it++) begin
      v1 = gen(it % 2);
      run(v1, 1'(($urandom_range(0, 1))), $urandom_range(0, 5),
          1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))));
`ifdef FC_ARGMAX_SCORE_BUF_EN
      if (it % 4 == 0) read_buf();
`endif
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
